month_row_fetch: RTL and testbench

Line-fetch controller for the calendar month-name pixel ROM. During horizontal blanking it sequences one row of MAX_X pixels of the selected month out of the two-port month memory into a ping-pong line buffer. The VGA pixel pipeline then reads the month strip from that buffer instead of addressing the ROM per pixel. It sits between the video timing generator and the month memory, and owns the ROM address port.

---
 rtl/month_fetch_pkg.sv | 25 ++
 rtl/month_line_buf.sv | 36 +++
 rtl/month_row_fetch.sv | 206 ++++++++++++++++++++
 tb/tb_month_row_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/month_fetch_pkg.sv
// Shared types and defaults for the month-name strip line fetcher.
package month_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

    localparam int DEF_MONTH_CNT = 12;
    localparam int DEF_MAX_X     = 130;
    localparam int DEF_MAX_Y     = 30;
    localparam int DEF_OFFSET    = 84;
    localparam int ROM_AW        = 13;

    // First ROM address of a strip row; callers guarantee y < MAX_Y so no wrap.
    function automatic logic [ROM_AW-1:0] row_base(input logic [ROM_AW-1:0] y,
                                                   input int unsigned max_x);
        logic [31:0] prod;
        prod = 32'(y) * 32'(max_x);
        return prod[ROM_AW-1:0];
    endfunction

endpackage

// File: rtl/month_line_buf.sv
// One half of the ping-pong strip buffer: single write port, registered read port.
module month_line_buf #(
    parameter int DEPTH = 130,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic          wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic          rdata_o
);

    logic mem_q [DEPTH];
    logic rdata_q;

    // Pixel storage, written by the fetch pipeline.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read for the pixel pipeline.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= 1'b0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/month_row_fetch.sv
// Fetches one month-strip row from ROM into a ping-pong line buffer during hblank
// and serves strip pixels to the video pipeline from the front buffer.
module month_row_fetch
    import month_fetch_pkg::*;
#(
    parameter int MONTH_CNT = DEF_MONTH_CNT,
    parameter int MAX_X     = DEF_MAX_X,
    parameter int MAX_Y     = DEF_MAX_Y,
    parameter int OFFSET    = DEF_OFFSET,
    parameter int PIX_X_W   = 12,
    parameter int PIX_Y_W   = 12,
    parameter int ROM_LAT   = 1,
    parameter int MONTH_W   = $clog2(MONTH_CNT)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [MONTH_W-1:0] month_i,
    input  logic               line_req_i,
    input  logic [PIX_Y_W-1:0] line_y_i,
    input  logic               line_swap_i,
    output logic               line_busy_o,
    output logic               line_done_o,
    output logic               underrun_o,
    output logic               overrun_o,
    output logic [ROM_AW-1:0]  rom_addr_o,
    output logic [MONTH_W-1:0] rom_month_o,
    input  logic               rom_pix_i,
    input  logic [PIX_X_W-1:0] rd_x_i,
    output logic               rd_pix_o
);

    localparam int XW = $clog2(MAX_X);
    localparam int LW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    fetch_state_e                    state_q, state_d;
    logic [XW-1:0]                   x_q, x_d;
    logic [ROM_AW-1:0]               addr_q, addr_d;
    logic [MONTH_W-1:0]              month_q, month_d;
    logic                            tgt_q, tgt_d;
    logic                            front_q, front_d;
    logic [1:0]                      valid_q, valid_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            underrun_q, underrun_d;
    logic                            overrun_q, overrun_d;
    logic [LW-1:0]                   drain_q, drain_d;
    logic [ROM_LAT-1:0]              pipe_v_q, pipe_v_d;
    logic [ROM_LAT-1:0][XW-1:0]      pipe_x_q, pipe_x_d;
    logic                            rd_ok_q, rd_ok_d;
    logic                            rd_sel_q, rd_sel_d;
    logic [XW-1:0]                   rd_addr_s;
    logic                            rd_in_s;
    logic [1:0]                      we_s;
    logic [1:0]                      rd_data_s;

    // Fetch sequencer, buffer bookkeeping and sticky error flags.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        addr_d     = addr_q;
        month_d    = month_q;
        tgt_d      = tgt_q;
        valid_d    = valid_q;
        drain_d    = drain_q;
        done_d     = 1'b0;
        front_d    = line_swap_i ? ~front_q : front_q;
        underrun_d = underrun_q | (line_swap_i & busy_q);
        overrun_d  = overrun_q | (line_req_i & (state_q != ST_IDLE));
        for (int i = ROM_LAT - 1; i > 0; i--) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_x_d[i] = pipe_x_q[i-1];
        end
        pipe_v_d[0] = (state_q == ST_ISSUE);
        pipe_x_d[0] = x_q;

        case (state_q)
            ST_IDLE: begin
                if (line_req_i) begin
                    month_d = month_i;
                    // A coincident swap has already moved front; fetch the new back.
                    tgt_d   = ~front_d;
                    if (line_y_i >= PIX_Y_W'(MAX_Y)) begin
                        valid_d[tgt_d] = 1'b0;
                        done_d         = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        addr_d  = row_base(ROM_AW'(line_y_i), MAX_X);
                        x_d     = '0;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (x_q == XW'(MAX_X - 1)) begin
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    x_d    = x_q + XW'(1);
                    addr_d = addr_q + 13'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == LW'(ROM_LAT - 1)) begin
                    valid_d[tgt_q] = 1'b1;
                    done_d         = 1'b1;
                    state_d        = ST_DONE;
                end else begin
                    drain_d = drain_q + LW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    end

    // Read-side address decode against the strip window.
    always_comb begin
        rd_in_s  = (rd_x_i >= PIX_X_W'(OFFSET)) && (rd_x_i < PIX_X_W'(OFFSET + MAX_X));
        rd_ok_d  = rd_in_s & valid_q[front_q];
        rd_sel_d = front_q;
        if (rd_in_s) begin
            rd_addr_s = XW'(rd_x_i - PIX_X_W'(OFFSET));
        end else begin
            rd_addr_s = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            addr_q     <= '0;
            month_q    <= '0;
            tgt_q      <= 1'b0;
            front_q    <= 1'b0;
            valid_q    <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            drain_q    <= '0;
            pipe_v_q   <= '0;
            pipe_x_q   <= '0;
            rd_ok_q    <= 1'b0;
            rd_sel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            addr_q     <= addr_d;
            month_q    <= month_d;
            tgt_q      <= tgt_d;
            front_q    <= front_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            drain_q    <= drain_d;
            pipe_v_q   <= pipe_v_d;
            pipe_x_q   <= pipe_x_d;
            rd_ok_q    <= rd_ok_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    assign we_s[0] = pipe_v_q[ROM_LAT-1] & ~tgt_q;
    assign we_s[1] = pipe_v_q[ROM_LAT-1] & tgt_q;

    month_line_buf #(.DEPTH(MAX_X), .AW(XW)) u_buf0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we_s[0]),
        .waddr_i (pipe_x_q[ROM_LAT-1]),
        .wdata_i (rom_pix_i),
        .raddr_i (rd_addr_s),
        .rdata_o (rd_data_s[0])
    );

    month_line_buf #(.DEPTH(MAX_X), .AW(XW)) u_buf1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we_s[1]),
        .waddr_i (pipe_x_q[ROM_LAT-1]),
        .wdata_i (rom_pix_i),
        .raddr_i (rd_addr_s),
        .rdata_o (rd_data_s[1])
    );

    assign line_busy_o = busy_q;
    assign line_done_o = done_q;
    assign underrun_o  = underrun_q;
    assign overrun_o   = overrun_q;
    assign rom_addr_o  = addr_q;
    assign rom_month_o = month_q;
    assign rd_pix_o    = rd_ok_q & (rd_sel_q ? rd_data_s[1] : rd_data_s[0]);

endmodule

// File: tb/tb_month_row_fetch.sv
// Directed bench for month_row_fetch with a timeline-based reference model.
module tb_month_row_fetch;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  month_i = 4'd0;
    logic        line_req_i = 1'b0;
    logic [11:0] line_y_i = 12'd0;
    logic        line_swap_i = 1'b0;
    logic        line_busy_o, line_done_o, underrun_o, overrun_o;
    logic [12:0] rom_addr_o;
    logic [3:0]  rom_month_o;
    logic        rom_pix_i = 1'b0;
    logic [11:0] rd_x_i = 12'd0;
    logic        rd_pix_o;

    int n_checks = 0;
    int n_errors = 0;

    month_row_fetch dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .month_i     (month_i),
        .line_req_i  (line_req_i),
        .line_y_i    (line_y_i),
        .line_swap_i (line_swap_i),
        .line_busy_o (line_busy_o),
        .line_done_o (line_done_o),
        .underrun_o  (underrun_o),
        .overrun_o   (overrun_o),
        .rom_addr_o  (rom_addr_o),
        .rom_month_o (rom_month_o),
        .rom_pix_i   (rom_pix_i),
        .rd_x_i      (rd_x_i),
        .rd_pix_o    (rd_pix_o)
    );

    always #5 clk = ~clk;

    // ROM with one cycle of latency; pixel = parity of the address.
    always @(posedge clk) rom_pix_i <= ^rom_addr_o;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference model: fetch described as a timeline relative to the request edge.
    bit         m_front, m_act, m_oor, m_tgt, m_under, m_over, m_rd;
    bit [1:0]   m_valid;
    bit         m_buf [2][130];
    int         m_k, m_y, m_month;

    initial begin
        bit idle_now, busy_now, end_now, exp_busy, exp_done;
        logic [12:0] a;
        int x;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                m_front = 1'b0; m_valid = 2'b00; m_act = 1'b0; m_under = 1'b0;
                m_over = 1'b0; m_month = 0; m_rd = 1'b0;
                check("rst_busy", line_busy_o, 0);
                check("rst_done", line_done_o, 0);
                check("rst_underrun", underrun_o, 0);
                check("rst_overrun", overrun_o, 0);
                check("rst_addr", rom_addr_o, 0);
                check("rst_month", rom_month_o, 0);
                check("rst_rdpix", rd_pix_o, 0);
            end else begin
                exp_busy = m_act && !m_oor && m_k <= 131;
                exp_done = m_act && (m_oor ? (m_k == 1) : (m_k == 132));
                check("busy", line_busy_o, 32'(exp_busy));
                check("done", line_done_o, 32'(exp_done));
                check("underrun", underrun_o, 32'(m_under));
                check("overrun", overrun_o, 32'(m_over));
                check("rom_month", rom_month_o, 32'(m_month));
                check("rd_pix", rd_pix_o, 32'(m_rd));
                if (m_act && !m_oor && m_k <= 130)
                    check("rom_addr", rom_addr_o, 32'(m_y * 130 + m_k - 1));

                idle_now = !m_act;
                busy_now = m_act && !m_oor && m_k <= 131;
                end_now  = exp_done;
                x = int'(rd_x_i);
                if (x >= 84 && x < 214 && m_valid[m_front]) m_rd = m_buf[m_front][x-84];
                else m_rd = 1'b0;
                if (line_req_i && !idle_now) m_over = 1'b1;
                if (line_swap_i && busy_now) m_under = 1'b1;
                if (line_swap_i) m_front = !m_front;
                if (m_act && !m_oor && m_k >= 2 && m_k <= 131) begin
                    a = 13'(m_y * 130 + m_k - 2);
                    m_buf[m_tgt][m_k-2] = ^a;
                end
                if (m_act && !m_oor && m_k == 131) m_valid[m_tgt] = 1'b1;
                if (end_now) m_act = 1'b0;
                else if (m_act) m_k++;
                if (line_req_i && idle_now) begin
                    m_act = 1'b1; m_k = 1; m_y = int'(line_y_i); m_month = int'(month_i);
                    m_tgt = !m_front; m_oor = (line_y_i >= 12'd30);
                    if (m_oor) m_valid[m_tgt] = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rd_x_i = 12'(i);
            tick(1);
        end
    endtask

    task automatic rd_at(input string name, input int xv, input bit exp_v);
        rd_x_i = 12'(xv);
        tick(1);
        check(name, rd_pix_o, 32'(exp_v));
    endtask

    task automatic swap_pulse();
        line_swap_i = 1'b1;
        tick(1);
        line_swap_i = 1'b0;
    endtask

    task automatic request(input int y, input int m);
        line_y_i = 12'(y);
        month_i = 4'(m);
        line_req_i = 1'b1;
        tick(1);
        line_req_i = 1'b0;
    endtask

    initial begin
        #1 rst_i = 1'b0;
        tick(3);
        check("lit_rst_addr", rom_addr_o, 0);
        check("lit_rst_busy", line_busy_o, 0);
        rst_i = 1'b1;
        tick(2);

        // Row fetch: month 3, row 5 -> addresses 650..779
        request(5, 3);
        month_i = 4'd7;
        check("lit_f1_addr_first", rom_addr_o, 650);
        check("lit_f1_month", rom_month_o, 3);
        check("lit_f1_busy", line_busy_o, 1);
        tick(129);
        check("lit_f1_addr_last", rom_addr_o, 779);
        tick(1);
        check("lit_f1_busy131", line_busy_o, 1);
        tick(1);
        check("lit_f1_done132", line_done_o, 1);
        check("lit_f1_busy132", line_busy_o, 0);
        tick(1);
        swap_pulse();
        sweep(80, 220);
        rd_at("lit_edge83", 83, 1'b0);
        rd_at("lit_edge84", 84, 1'b0);
        rd_at("lit_x85", 85, 1'b1);
        rd_at("lit_edge213", 213, 1'b1);
        rd_at("lit_edge214", 214, 1'b0);

        // Out-of-range row
        request(30, 2);
        check("lit_oor_done1", line_done_o, 1);
        check("lit_oor_busy", line_busy_o, 0);
        tick(1);
        check("lit_oor_done2", line_done_o, 0);
        swap_pulse();
        sweep(80, 220);
        rd_at("lit_oor_rd150", 150, 1'b0);

        // Overrun at cycle 50, underrun at cycle 60
        rd_x_i = 12'd100;
        request(7, 9);
        tick(49);
        request(12, 4);
        check("lit_overrun", overrun_o, 1);
        tick(9);
        swap_pulse();
        check("lit_underrun", underrun_o, 1);
        tick(71);
        check("lit_ovr_done", line_done_o, 1);
        tick(2);

        // Simultaneous swap + request in idle
        line_swap_i = 1'b1;
        request(2, 1);
        line_swap_i = 1'b0;
        sweep(84, 213);
        tick(5);
        swap_pulse();
        rd_at("lit_sim_x84", 84, 1'b0);
        rd_at("lit_sim_x85", 85, 1'b1);

        // Reset at cycle 70 of a fetch
        request(10, 6);
        tick(69);
        rst_i = 1'b0;
        #1;
        check("lit_mrst_busy", line_busy_o, 0);
        check("lit_mrst_addr", rom_addr_o, 0);
        check("lit_mrst_ovr", overrun_o, 0);
        check("lit_mrst_und", underrun_o, 0);
        tick(2);
        rst_i = 1'b1;
        tick(2);
        sweep(80, 220);
        swap_pulse();
        rd_at("lit_mrst_rd", 100, 1'b0);

        // Last row after reset: 3770..3899
        request(29, 11);
        check("lit_r29_first", rom_addr_o, 3770);
        tick(129);
        check("lit_r29_last", rom_addr_o, 3899);
        tick(2);
        check("lit_r29_done", line_done_o, 1);
        tick(2);
        swap_pulse();
        rd_at("lit_r29_x213", 213, 1'b1);
        rd_at("lit_r29_x84", 84, 1'b0);
        sweep(80, 220);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
